// File: rtl/display_scheduler_if.sv
// rtl/display_scheduler_if.sv - Request, button and select signals of the display scheduler
interface display_scheduler_if;
    logic        comp_req;
    logic [3:0]  comp_sel;
    logic        mode_auto;
    logic [3:0]  manual_sel;
    logic [15:0] en_mask;
    logic        btn_next;
    logic        btn_prev;
    logic        btn_hold;
    logic [3:0]  sel;
    logic        direct;
    logic        sel_changed;
    logic [1:0]  state;

    modport master (
        output comp_req, comp_sel, mode_auto, manual_sel, en_mask,
               btn_next, btn_prev, btn_hold,
        input  sel, direct, sel_changed, state
    );

    modport slave (
        input  comp_req, comp_sel, mode_auto, manual_sel, en_mask,
               btn_next, btn_prev, btn_hold,
        output sel, direct, sel_changed, state
    );
endinterface

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - Arbitrates computer, manual and auto-scan selection of the display source
module display_scheduler #(
    parameter int TICK_DIV = 1000,
    parameter int DWELL    = 2000
) (
    input  logic               clk,
    input  logic               reset,
    display_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        MAN   = 2'd0,
        COMP  = 2'd1,
        SCAN  = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam int TW = $clog2(TICK_DIV);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;

    state_t          state, state_nxt;
    logic [3:0]      sel, sel_nxt, sel_q;
    logic            direct, sel_changed;
    logic [TW-1:0]   tick_cnt;
    logic [DW-1:0]   dwell_cnt, dwell_nxt;
    logic            next_q, prev_q, hold_q;
    logic            next_e, prev_e, hold_e;
    logic            tick, expire, step_fwd, step_back;

    // Search excludes the current index; with no other enabled bit the index is kept.
    function automatic logic [3:0] search_up(input logic [3:0] cur, input logic [15:0] mask);
        logic [3:0] res;
        logic [3:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < 16; k++) begin
            idx = cur + 4'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] search_down(input logic [3:0] cur, input logic [15:0] mask);
        logic [3:0] res;
        logic [3:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < 16; k++) begin
            idx = cur - 4'(k);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
    assign expire    = (state == SCAN) && tick && (dwell_cnt == DW'(DWELL - 1));
    assign step_fwd  = next_e & ~prev_e;
    assign step_back = prev_e & ~next_e;

    always_comb begin
        state_nxt = state;
        if (bus.comp_req)
            state_nxt = COMP;
        else if (!bus.mode_auto)
            state_nxt = MAN;
        else if (state == PAUSE)
            state_nxt = hold_e ? SCAN : PAUSE;
        else if (state == SCAN)
            state_nxt = hold_e ? PAUSE : SCAN;
        else
            state_nxt = SCAN;
    end

    // Dwell is held at zero outside SCAN, so every entry to SCAN starts a fresh period.
    always_comb begin
        sel_nxt   = sel;
        dwell_nxt = '0;
        unique case (state)
            MAN:  sel_nxt = bus.manual_sel;
            COMP: sel_nxt = bus.comp_sel;
            SCAN, PAUSE: begin
                if (step_back)
                    sel_nxt = search_down(sel, bus.en_mask);
                else if (step_fwd || expire)
                    sel_nxt = search_up(sel, bus.en_mask);
                if (state == SCAN && !(step_fwd || step_back || expire))
                    dwell_nxt = tick ? dwell_cnt + DW'(1) : dwell_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= MAN;
            sel         <= '0;
            sel_q       <= '0;
            direct      <= 1'b0;
            sel_changed <= 1'b0;
            tick_cnt    <= '0;
            dwell_cnt   <= '0;
            next_q      <= 1'b0;
            prev_q      <= 1'b0;
            hold_q      <= 1'b0;
            next_e      <= 1'b0;
            prev_e      <= 1'b0;
            hold_e      <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel         <= sel_nxt;
            sel_q       <= sel;
            direct      <= (sel_nxt == 4'd10);
            sel_changed <= (sel != sel_q);
            tick_cnt    <= tick ? '0 : tick_cnt + TW'(1);
            dwell_cnt   <= dwell_nxt;
            next_q      <= bus.btn_next;
            prev_q      <= bus.btn_prev;
            hold_q      <= bus.btn_hold;
            next_e      <= bus.btn_next & ~next_q;
            prev_e      <= bus.btn_prev & ~prev_q;
            hold_e      <= bus.btn_hold & ~hold_q;
        end
    end

    assign bus.sel         = sel;
    assign bus.direct      = direct;
    assign bus.sel_changed = sel_changed;
    assign bus.state       = state;
endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - Randomized self-checking bench for display_scheduler
module tb_display_scheduler;
    localparam int TD = 4;
    localparam int DW = 3;

    logic clk;
    logic reset;
    display_scheduler_if bus ();

    display_scheduler #(.TICK_DIV(TD), .DWELL(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: states 0 MAN, 1 COMP, 2 SCAN, 3 PAUSE
    int m_state, m_sel, m_seld, m_chg, m_dir, m_cyc, m_dwell;
    int m_bn, m_bp, m_bh, m_en, m_ep, m_eh;

    function automatic int find_next(int cur, logic [15:0] m);
        for (int i = cur + 1; i < 16; i++) if (m[i]) return i;
        for (int i = 0; i < cur; i++) if (m[i]) return i;
        return cur;
    endfunction

    function automatic int find_prev(int cur, logic [15:0] m);
        for (int i = cur - 1; i >= 0; i--) if (m[i]) return i;
        for (int i = 15; i > cur; i--) if (m[i]) return i;
        return cur;
    endfunction

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_seld = 0; m_chg = 0; m_dir = 0; m_cyc = 0; m_dwell = 0;
        m_bn = 0; m_bp = 0; m_bh = 0; m_en = 0; m_ep = 0; m_eh = 0;
    endtask

    task automatic model_step();
        int tick, ns, nsel, nd, fwd, back, expd;
        tick = ((m_cyc % TD) == TD - 1);
        if (bus.comp_req)        ns = 1;
        else if (!bus.mode_auto) ns = 0;
        else if (m_state == 3)   ns = m_eh ? 2 : 3;
        else if (m_state == 2)   ns = m_eh ? 3 : 2;
        else                     ns = 2;
        nsel = m_sel;
        nd   = 0;
        if (m_state == 0)      nsel = bus.manual_sel;
        else if (m_state == 1) nsel = bus.comp_sel;
        else begin
            fwd  = m_en && !m_ep;
            back = m_ep && !m_en;
            expd = (m_state == 2) && tick && (m_dwell == DW - 1);
            if (back)             nsel = find_prev(m_sel, bus.en_mask);
            else if (fwd || expd) nsel = find_next(m_sel, bus.en_mask);
            if (m_state == 2) nd = (fwd || back || expd) ? 0 : m_dwell + tick;
        end
        m_chg   = (m_sel != m_seld);
        m_seld  = m_sel;
        m_sel   = nsel;
        m_dir   = (nsel == 10);
        m_state = ns;
        m_dwell = nd;
        m_en = bus.btn_next && !m_bn;
        m_ep = bus.btn_prev && !m_bp;
        m_eh = bus.btn_hold && !m_bh;
        m_bn = bus.btn_next;
        m_bp = bus.btn_prev;
        m_bh = bus.btn_hold;
        m_cyc++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.comp_req = 0; bus.comp_sel = 0; bus.mode_auto = 0; bus.manual_sel = 4'd5;
        bus.en_mask = 16'h0; bus.btn_next = 0; bus.btn_prev = 0; bus.btn_hold = 0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (bus.sel !== 4'd0) $display("FAIL reset_sel got %0d want 0", bus.sel); else n_pass++;
        n_chk++; if (bus.state !== 2'd0) $display("FAIL reset_state got %0d want 0", bus.state); else n_pass++;
        n_chk++; if (bus.direct !== 1'b0) $display("FAIL reset_direct got %0b want 0", bus.direct); else n_pass++;
        n_chk++; if (bus.sel_changed !== 1'b0) $display("FAIL reset_chg got %0b want 0", bus.sel_changed); else n_pass++;
        reset = 1'b1;
        model_reset();
        cycle();
        n_chk++; if (bus.sel !== 4'd5) $display("FAIL rel_sel got %0d want 5", bus.sel); else n_pass++;
        n_chk++; if (bus.direct !== 1'b0) $display("FAIL rel_direct got %0b want 0", bus.direct); else n_pass++;
        cycle();
        n_chk++; if (bus.sel_changed !== 1'b1) $display("FAIL rel_chg1 got %0b want 1", bus.sel_changed); else n_pass++;
        cycle();
        n_chk++; if (bus.sel_changed !== 1'b0) $display("FAIL rel_chg2 got %0b want 0", bus.sel_changed); else n_pass++;
    endtask

    task automatic test_scan_sequence();
        int chg_cyc[$];
        int chg_val[$];
        logic [3:0] last;
        int exp_val[3];
        exp_val = '{1, 4, 0};
        bus.manual_sel = 4'd0;
        bus.en_mask = 16'h0013;
        repeat (3) cycle();
        bus.mode_auto = 1;
        last = bus.sel;
        for (int c = 0; c < 45; c++) begin
            cycle();
            n_chk++; if (bus.sel !== 4'(m_sel)) $display("FAIL scan_sel c%0d got %0d want %0d", c, bus.sel, m_sel); else n_pass++;
            n_chk++; if (bus.sel_changed !== 1'(m_chg)) $display("FAIL scan_chg c%0d got %0b want %0d", c, bus.sel_changed, m_chg); else n_pass++;
            if (bus.sel !== last) begin
                chg_cyc.push_back(c);
                chg_val.push_back(int'(bus.sel));
                last = bus.sel;
            end
        end
        n_chk++;
        if (chg_val.size() < 3) $display("FAIL scan_steps got %0d want >=3", chg_val.size());
        else begin
            n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (chg_val[i] != exp_val[i]) $display("FAIL scan_val%0d got %0d want %0d", i, chg_val[i], exp_val[i]); else n_pass++;
            end
            for (int i = 1; i < 3; i++) begin
                n_chk++; if (chg_cyc[i] - chg_cyc[i-1] != 12) $display("FAIL scan_period%0d got %0d want 12", i, chg_cyc[i] - chg_cyc[i-1]); else n_pass++;
            end
        end
    endtask

    task automatic test_comp();
        bus.comp_req = 1; bus.comp_sel = 4'd10;
        cycle();
        n_chk++; if (bus.state !== 2'd1) $display("FAIL comp_state got %0d want 1", bus.state); else n_pass++;
        cycle();
        n_chk++; if (bus.sel !== 4'd10) $display("FAIL comp_sel got %0d want 10", bus.sel); else n_pass++;
        n_chk++; if (bus.direct !== 1'b1) $display("FAIL comp_direct got %0b want 1", bus.direct); else n_pass++;
        bus.comp_req = 0;
        cycle();
        n_chk++; if (bus.state !== 2'd2) $display("FAIL comp_exit_state got %0d want 2", bus.state); else n_pass++;
        for (int c = 0; c < 8; c++) begin
            cycle();
            n_chk++; if (bus.sel !== 4'd10) $display("FAIL comp_hold c%0d got %0d want 10", c, bus.sel); else n_pass++;
        end
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_chk++; if (bus.sel !== 4'(m_sel)) $display("FAIL comp_resume c%0d got %0d want %0d", c, bus.sel, m_sel); else n_pass++;
        end
    endtask

    task automatic test_pause();
        int frz;
        bus.en_mask = 16'h8001;
        bus.btn_hold = 1;
        cycle(); cycle();
        n_chk++; if (bus.state !== 2'd3) $display("FAIL pause_state got %0d want 3", bus.state); else n_pass++;
        bus.btn_hold = 0;
        frz = m_sel;
        for (int c = 0; c < 100 * TD; c++) begin
            cycle();
            n_chk++; if (bus.sel !== 4'(frz)) $display("FAIL pause_frozen c%0d got %0d want %0d", c, bus.sel, frz); else n_pass++;
        end
        for (int k = 0; k < 2 && m_sel != 0; k++) begin
            bus.btn_next = 1; cycle(); bus.btn_next = 0; cycle(); cycle();
        end
        n_chk++; if (bus.sel !== 4'd0) $display("FAIL pause_next got %0d want 0", bus.sel); else n_pass++;
        bus.btn_prev = 1; cycle(); cycle();
        n_chk++; if (bus.sel !== 4'd15) $display("FAIL pause_prev got %0d want 15", bus.sel); else n_pass++;
        bus.btn_prev = 0; cycle();
        bus.btn_hold = 1; cycle(); cycle();
        n_chk++; if (bus.state !== 2'd2) $display("FAIL pause_resume got %0d want 2", bus.state); else n_pass++;
        bus.btn_hold = 0; cycle();
    endtask

    task automatic test_empty_mask();
        int frz;
        bus.en_mask = 16'h0;
        cycle(); cycle();
        frz = m_sel;
        for (int c = 0; c < 50 * DW * TD; c++) begin
            cycle();
            if (bus.sel !== 4'(frz) || bus.sel_changed !== 1'b0) begin
                n_chk++;
                $display("FAIL empty_hold c%0d got sel %0d chg %0b want sel %0d chg 0", c, bus.sel, bus.sel_changed, frz);
            end else begin
                n_chk++; n_pass++;
            end
        end
        bus.btn_hold = 1; cycle(); cycle(); bus.btn_hold = 0;
        n_chk++; if (bus.state !== 2'd3) $display("FAIL both_pause got %0d want 3", bus.state); else n_pass++;
        bus.en_mask = 16'h0013;
        bus.btn_next = 1; bus.btn_prev = 1;
        cycle(); cycle();
        bus.btn_next = 0; bus.btn_prev = 0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            n_chk++; if (bus.sel !== 4'(frz)) $display("FAIL both_btn c%0d got %0d want %0d", c, bus.sel, frz); else n_pass++;
        end
        bus.btn_hold = 1; cycle(); cycle(); bus.btn_hold = 0; cycle();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(63) == 0) bus.comp_req = ~bus.comp_req;
            if ($urandom_range(99) == 0) bus.mode_auto = ~bus.mode_auto;
            if ($urandom_range(5) == 0) bus.btn_next = ~bus.btn_next;
            if ($urandom_range(5) == 0) bus.btn_prev = ~bus.btn_prev;
            if ($urandom_range(40) == 0) bus.btn_hold = ~bus.btn_hold;
            if ($urandom_range(9) == 0) bus.manual_sel = 4'($urandom);
            if ($urandom_range(9) == 0) bus.comp_sel = 4'($urandom);
            if ($urandom_range(199) == 0) bus.en_mask = 16'($urandom) & 16'($urandom);
            cycle();
            n_chk++; if (bus.sel !== 4'(m_sel)) $display("FAIL rnd_sel c%0d got %0d want %0d", c, bus.sel, m_sel); else n_pass++;
            n_chk++; if (bus.state !== 2'(m_state)) $display("FAIL rnd_state c%0d got %0d want %0d", c, bus.state, m_state); else n_pass++;
            n_chk++; if (bus.direct !== 1'(m_dir)) $display("FAIL rnd_direct c%0d got %0b want %0d", c, bus.direct, m_dir); else n_pass++;
            n_chk++; if (bus.sel_changed !== 1'(m_chg)) $display("FAIL rnd_chg c%0d got %0b want %0d", c, bus.sel_changed, m_chg); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        bus.comp_req = 0; bus.mode_auto = 1; bus.en_mask = 16'h0013;
        bus.btn_next = 0; bus.btn_prev = 0; bus.btn_hold = 0;
        repeat (21) cycle();
        n_chk++; if (bus.state !== 2'd2) $display("FAIL mid_pre_state got %0d want 2", bus.state); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_chk++; if (bus.sel !== 4'd0) $display("FAIL mid_sel got %0d want 0", bus.sel); else n_pass++;
        n_chk++; if (bus.state !== 2'd0) $display("FAIL mid_state got %0d want 0", bus.state); else n_pass++;
        n_chk++; if (bus.direct !== 1'b0) $display("FAIL mid_direct got %0b want 0", bus.direct); else n_pass++;
        n_chk++; if (bus.sel_changed !== 1'b0) $display("FAIL mid_chg got %0b want 0", bus.sel_changed); else n_pass++;
        @(posedge clk);
        #1;
        bus.mode_auto = 0; bus.manual_sel = 4'd7;
        reset = 1'b1;
        model_reset();
        cycle();
        n_chk++; if (bus.state !== 2'd0) $display("FAIL mid_release_state got %0d want 0", bus.state); else n_pass++;
        n_chk++; if (bus.sel !== 4'd7) $display("FAIL mid_release_sel got %0d want 7", bus.sel); else n_pass++;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_scan_sequence();
        test_comp();
        test_pause();
        test_empty_mask();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/display_scheduler.md
# display_scheduler

Selects which of the 16 display sources drives the 7-segment display and when. It arbitrates between three requesters: computer control (board-control register), manual switch selection, and an automatic round-robin scan over an enable mask with a programmable dwell time. Button stepping and pause are available during the scan. The block sits between the switch/button synchronisers and the display-source mux, and its `sel` output replaces the direct switch/board-control select.

## Interface
Parameters:
- `TICK_DIV`, 1000: `clk` cycles per tick (1 ms at 1 MHz). Minimum 2.
- `DWELL`, 2000: ticks a source stays selected in auto scan. Minimum 1.

Ports:
- `clk`  in  1: single clock (display-driver clock domain).
- `reset`  in  1: asynchronous, active-low reset. Asserted at 0.
- `comp_req`  in  1: computer override request (board-control bit 0).
- `comp_sel`  in  4: source requested by the computer.
- `mode_auto`  in  1: 1 selects auto scan, 0 selects manual.
- `manual_sel`  in  4: switch-selected source.
- `en_mask`  in  16: sources included in auto scan; bit i enables source i.
- `btn_next`, `btn_prev`, `btn_hold`  in  1 each: debounced, synchronous levels.
- `sel`  out  4: registered display-source select.
- `direct`  out  1: registered; 1 exactly when `sel` == 10 (raw pixel mode).
- `sel_changed`  out  1: one-cycle pulse in the cycle after `sel` took a new value.
- `state`  out  2: current FSM state, for debug display.

## Operation
FSM states and encodings: MAN = 0, COMP = 1, SCAN = 2, PAUSE = 3.

State selection is evaluated every cycle, in this priority:
- `comp_req` = 1 moves the FSM to COMP from any state.
- Otherwise, if `mode_auto` = 0, the FSM moves to MAN.
- Otherwise, a FSM in PAUSE stays in PAUSE; any other state moves to SCAN.
- SCAN to PAUSE on a `btn_hold` rising edge; PAUSE to SCAN on a `btn_hold` rising edge.
- Leaving COMP with `mode_auto` = 1 always enters SCAN, never PAUSE.

Select value per state:
- MAN: `sel` <= `manual_sel` every cycle.
- COMP: `sel` <= `comp_sel` every cycle.
- SCAN: `sel` advances to the next enabled index after `sel`, searching upward with wrap 15 -> 0. An advance happens on dwell expiry or on a `btn_next` rising edge. A `btn_prev` rising edge steps to the previous enabled index, searching downward with wrap 0 -> 15.
- PAUSE: `sel` is frozen; `btn_next` and `btn_prev` still step it. The dwell counter is held at 0.
- On entry to SCAN, `sel` keeps its current value and the dwell counter restarts at 0.

Button handling:
- Rising edges are detected against a registered copy of each button, so an edge is a 0 -> 1 between consecutive cycles.
- Edges are ignored outside SCAN and PAUSE; only the `btn_hold` edge that toggles SCAN/PAUSE is acted on there.
- `btn_next` and `btn_prev` edges in the same cycle are both ignored.

Search rules:
- The search excludes the current index.
- If the current index is the only enabled bit, `sel` is unchanged.
- If `en_mask` == 0, `sel` holds and `sel_changed` stays 0.
- If the current `sel` is not enabled, the search still starts from it.

## Timing
Reset values (all outputs and internal registers):
- `state` = MAN, `sel` = 0, `direct` = 0, `sel_changed` = 0.
- Tick counter, dwell counter and button edge registers = 0.

Counters:
- The tick counter counts 0..`TICK_DIV`-1 and emits a tick when it wraps. It runs in every state.
- The dwell counter increments on ticks in SCAN only. It expires on a tick when dwell_cnt == `DWELL`-1, then clears.
- Any step, whether by dwell expiry or by button, clears the dwell counter.
- A button step coinciding with dwell expiry produces exactly one step, in the button's direction.

Latency:
- An input change (`manual_sel`, `comp_sel`) reaches `sel` 1 cycle after the state is reached.
- A state change itself takes 1 cycle.
- From a button level rising to `sel` updating takes 2 cycles: 1 cycle for edge registration, 1 for the update.
- `direct` updates in the same cycle as `sel`.
- `sel_changed` is asserted 1 cycle after `sel` changes.

Reset mid-operation clears immediately (asynchronous) and forces all reset values. Deassertion is synchronised outside this block.

## Test plan
- Reset then release with `mode_auto` = 0, `manual_sel` = 5: `sel` = 0 during reset; `sel` = 5 and `direct` = 0 within 2 cycles; `sel_changed` pulses once.
- `TICK_DIV` = 4, `DWELL` = 3, `mode_auto` = 1, `en_mask` = 16'h0013, starting from `sel` = 0: `sel` steps 0 -> 1 -> 4 -> 0 every 12 cycles, with one `sel_changed` pulse per step.
- During SCAN, assert `comp_req` with `comp_sel` = 10: `state` = 1 and `sel` = 10 with `direct` = 1. Drop `comp_req`: `state` = 2, `sel` stays 10, and the dwell restarts.
- `btn_hold` edge during SCAN: `state` = 3 and `sel` frozen over 100 ticks. A `btn_prev` edge with `sel` = 0 and `en_mask` = 16'h8001 gives `sel` = 15. A second `btn_hold` edge resumes SCAN.
- `en_mask` = 0 in SCAN for 50 dwell periods: `sel` is constant and `sel_changed` is never asserted. `btn_next` and `btn_prev` edges in the same cycle cause no step.
- Reset asserted mid-SCAN between ticks: all outputs return to reset values within the same cycle; after release the FSM is in MAN.
